// File: rtl/ddram_byte_bridge.sv
// ddram_byte_bridge
//   Byte-wide load/play port (addr/din/dout/we/rd/ready) to 64-bit DDRAM
//   Avalon bridge with a one-line read cache, clocked on clk_sys.
//   Optional feature macro: DDRB_PREFETCH_EN (128-bit line, two-beat bursts).
module ddram_byte_bridge #(
  parameter int unsigned AW      = 28,
  parameter logic [3:0]  BASE_HI = 4'b0011
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  input  logic          we,
  input  logic          rd,
  output logic [7:0]    dout,
  output logic          ready,
  input  logic          DDRAM_BUSY,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic [28:0]   DDRAM_ADDR,
  input  logic [63:0]   DDRAM_DOUT,
  input  logic          DDRAM_DOUT_READY,
  output logic          DDRAM_RD,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE
);

`ifdef DDRB_PREFETCH_EN
  localparam int unsigned OFS   = 4;
  localparam logic [7:0]  BURST = 8'd2;
`else
  localparam int unsigned OFS   = 3;
  localparam logic [7:0]  BURST = 8'd1;
`endif
  localparam int unsigned LW = 8 << OFS;   // cache line width in bits
  localparam int unsigned TW = AW - OFS;   // tag width

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic          ready_r, ready_s;
  logic [7:0]    dout_r, dout_s;
  logic          rd_r, rd_s;
  logic          we_r, we_s;
  logic [28:0]   addr_out_r, addr_out_s;
  logic [7:0]    burst_r, burst_s;
  logic [63:0]   din_out_r, din_out_s;
  logic [7:0]    be_r, be_s;
  logic          valid_r, valid_s;
  logic [TW-1:0] tag_r, tag_s;
  logic [LW-1:0] line_r, line_s;
  logic [AW-1:0] req_r, req_s;
  logic          beat_r, beat_s;          // set once the first beat of a burst is in
  // Outstanding DDRAM beats; deliberately kept across reset so that beats of an
  // abandoned read are drained before a new read is issued.
  logic [3:0]    pend_r = 4'd0;
  // Distinguishes power-up reset (clears dout) from later resets (dout held).
  logic          first_done_r = 1'b0;

  logic          accept_s;
  logic          hit_s;
  logic          last_beat_s;
  logic          cmd_rd_s;
  logic [3:0]    pend_inc_s;
  logic [3:0]    pend_dec_s;
  logic [LW-1:0] fill_s;

  // Byte lane idx of a cache line, little-endian.
  function automatic logic [7:0] line_byte(input logic [LW-1:0] line, input logic [OFS-1:0] idx);
    return line[{idx, 3'b000} +: 8];
  endfunction

  // 64-bit word address of a read miss (burst-aligned when prefetching).
  function automatic logic [28:0] rd_word(input logic [AW-1:0] a);
`ifdef DDRB_PREFETCH_EN
    return {BASE_HI, a[AW-1:4], 1'b0};
`else
    return {BASE_HI, a[AW-1:3]};
`endif
  endfunction

  // Command acceptance by DDRAM and the beat bookkeeping derived from it.
  always_comb begin
    cmd_rd_s   = rd_r && !DDRAM_BUSY;
    pend_inc_s = 4'd0;
    pend_dec_s = 4'd0;
    if (cmd_rd_s) begin
      pend_inc_s = BURST[3:0];
    end else begin
      pend_inc_s = 4'd0;
    end
    if (DDRAM_DOUT_READY && (pend_r != 4'd0)) begin
      pend_dec_s = 4'd1;
    end else begin
      pend_dec_s = 4'd0;
    end
  end

  // Next-state and next-output logic of the request FSM.
  always_comb begin
    state_s    = state_r;
    ready_s    = ready_r;
    dout_s     = dout_r;
    rd_s       = rd_r;
    we_s       = we_r;
    addr_out_s = addr_out_r;
    burst_s    = burst_r;
    din_out_s  = din_out_r;
    be_s       = be_r;
    valid_s    = valid_r;
    tag_s      = tag_r;
    line_s     = line_r;
    req_s      = req_r;
    beat_s     = beat_r;

    // Ready is only ever high in IDLE or DONE; DONE behaves as idle once ready.
    accept_s    = ready_r && ((state_r == ST_IDLE) || (state_r == ST_DONE)) && (rd || we);
    hit_s       = valid_r && (tag_r == addr[AW-1:OFS]);
    last_beat_s = beat_r || (BURST == 8'd1);
`ifdef DDRB_PREFETCH_EN
    fill_s = {DDRAM_DOUT, line_r[63:0]};
`else
    fill_s = DDRAM_DOUT;
`endif

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          ready_s = 1'b0;
          req_s   = addr;
          if (we) begin
            state_s    = ST_WR_REQ;
            we_s       = 1'b1;
            addr_out_s = {BASE_HI, addr[AW-1:3]};
            burst_s    = 8'd1;
            din_out_s  = {8{din}};
            be_s       = 8'd1 << addr[2:0];
          end else if (hit_s) begin
            state_s = ST_DONE;
            dout_s  = line_byte(line_r, addr[OFS-1:0]);
          end else begin
            state_s    = ST_RD_REQ;
            rd_s       = (pend_r == 4'd0);
            addr_out_s = rd_word(addr);
            burst_s    = BURST;
          end
        end else begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (rd_r) begin
          if (!DDRAM_BUSY) begin
            rd_s    = 1'b0;
            beat_s  = 1'b0;
            state_s = ST_RD_WAIT;
          end else begin
            rd_s = 1'b1;
          end
        end else if (pend_r == 4'd0) begin
          rd_s = 1'b1;
        end else begin
          rd_s = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          if (last_beat_s) begin
            line_s  = fill_s;
            valid_s = 1'b1;
            tag_s   = req_r[AW-1:OFS];
            dout_s  = line_byte(fill_s, req_r[OFS-1:0]);
            ready_s = 1'b1;
            state_s = ST_DONE;
          end else begin
            line_s[63:0] = DDRAM_DOUT;
            beat_s       = 1'b1;
          end
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      ST_WR_REQ: begin
        if (!DDRAM_BUSY) begin
          we_s    = 1'b0;
          ready_s = 1'b1;
          state_s = ST_DONE;
          // Keep the cached copy coherent instead of invalidating it.
          if (valid_r && (tag_r == req_r[AW-1:OFS])) begin
            line_s[{req_r[OFS-1:0], 3'b000} +: 8] = din_out_r[7:0];
          end else begin
            line_s = line_r;
          end
        end else begin
          we_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
        rd_s    = 1'b0;
        we_s    = 1'b0;
      end
    endcase
  end

  // FSM state, cache line and registered DDRAM/port outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ready_r      <= 1'b1;
      rd_r         <= 1'b0;
      we_r         <= 1'b0;
      burst_r      <= 8'd1;
      be_r         <= 8'd0;
      valid_r      <= 1'b0;
      beat_r       <= 1'b0;
      addr_out_r   <= {BASE_HI, 25'd0};
      din_out_r    <= 64'd0;
      first_done_r <= 1'b1;
      if (!first_done_r) begin
        dout_r <= 8'd0;
      end else begin
        dout_r <= dout_r;
      end
    end else begin
      state_r    <= state_s;
      ready_r    <= ready_s;
      dout_r     <= dout_s;
      rd_r       <= rd_s;
      we_r       <= we_s;
      addr_out_r <= addr_out_s;
      burst_r    <= burst_s;
      din_out_r  <= din_out_s;
      be_r       <= be_s;
      valid_r    <= valid_s;
      tag_r      <= tag_s;
      line_r     <= line_s;
      req_r      <= req_s;
      beat_r     <= beat_s;
    end
  end

  // Outstanding-beat counter, intentionally independent of reset.
  always_ff @(posedge clk_sys) begin
    pend_r <= pend_r + pend_inc_s - pend_dec_s;
  end

  assign dout           = dout_r;
  assign ready          = ready_r;
  assign DDRAM_RD       = rd_r;
  assign DDRAM_WE       = we_r;
  assign DDRAM_ADDR     = addr_out_r;
  assign DDRAM_BURSTCNT = burst_r;
  assign DDRAM_DIN      = din_out_r;
  assign DDRAM_BE       = be_r;

endmodule

// File: tb/tb_ddram_byte_bridge.sv
// tb_ddram_byte_bridge: directed plus randomized checks of ddram_byte_bridge
// against a byte-level memory reference model and a simple DDRAM responder.
module tb_ddram_byte_bridge;

`ifdef DDRB_PREFETCH_EN
  localparam int OFS   = 4;
  localparam int BEATS = 2;
`else
  localparam int OFS   = 3;
  localparam int BEATS = 1;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [27:0] addr;
  logic [7:0]  din;
  logic        we;
  logic        rd;
  logic [7:0]  dout;
  logic        ready;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  always #5 clk_sys = ~clk_sys;

  ddram_byte_bridge dut (
    .clk_sys(clk_sys), .reset(reset), .addr(addr), .din(din), .we(we), .rd(rd),
    .dout(dout), .ready(ready), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  int checks_n = 0;
  int errors_n = 0;

  // DDRAM responder state
  logic       busy_force = 1'b0;
  logic       busy_rnd   = 1'b0;
  logic       rand_busy_en = 1'b0;
  int         rd_lat = 3;
  logic [7:0] ddr_mem [int];
  logic [7:0] ref_mem [int];
  int cyc = 0, rd_cmds = 0, wr_cmds = 0, beats_served = 0, bad_base = 0, last_cmd_cyc = 0;
  int q_word[$];
  int q_due[$];
  int beat_cyc_q[$];
  int srv_w;

  assign DDRAM_BUSY = busy_force | busy_rnd;

  function automatic logic [7:0] init_byte(input int a);
    logic [7:0] t;
    t = 8'(a);
    return t * 8'd3 + 8'd1;
  endfunction

  function automatic logic [7:0] ddr_rd(input int a);
    if (ddr_mem.exists(a)) return ddr_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [27:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_byte(int'(a));
  endfunction

  function automatic logic [28:0] exp_word(input logic [27:0] a);
    logic [24:0] w;
    w = a[27:3];
    if (OFS == 4) w[0] = 1'b0;
    return {4'b0011, w};
  endfunction

  // Responder: accepts commands at the clock edge, applies writes, queues beats.
  always @(posedge clk_sys) begin
    if (DDRAM_RD && !DDRAM_BUSY) begin
      rd_cmds++;
      last_cmd_cyc = cyc;
      if (DDRAM_ADDR[28:25] !== 4'b0011) bad_base++;
      for (int i = 0; i < int'(DDRAM_BURSTCNT); i++) begin
        q_word.push_back((int'(DDRAM_ADDR[24:0]) + i) & 32'h1FFFFFF);
        q_due.push_back(cyc + rd_lat + i);
      end
    end
    if (DDRAM_WE && !DDRAM_BUSY) begin
      wr_cmds++;
      if (DDRAM_ADDR[28:25] !== 4'b0011) bad_base++;
      for (int i = 0; i < 8; i++)
        if (DDRAM_BE[i]) ddr_mem[int'(DDRAM_ADDR[24:0]) * 8 + i] = DDRAM_DIN[8*i +: 8];
    end
    cyc++;
  end

  // Responder: presents at most one read beat per cycle, plus random stalls.
  always @(negedge clk_sys) begin
    DDRAM_DOUT_READY = 1'b0;
    busy_rnd = rand_busy_en && ($urandom_range(0, 2) == 0);
    if (q_word.size() > 0 && cyc >= q_due[0]) begin
      srv_w = q_word.pop_front();
      void'(q_due.pop_front());
      for (int i = 0; i < 8; i++) DDRAM_DOUT[8*i +: 8] = ddr_rd(srv_w * 8 + i);
      DDRAM_DOUT_READY = 1'b1;
      beats_served++;
      beat_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_n++;
    assert (obs === exp) else begin
      errors_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic r, input logic w, input logic [27:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    addr = a; din = d; rd = r; we = w;
    @(negedge clk_sys);
    rd = 1'b0; we = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 1;
    while (!ready && lat < 300) begin
      @(negedge clk_sys);
      lat++;
    end
    chk("ready_timeout", 64'(lat < 300), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rc0, wc0, b0, n, stale_cyc;
    logic [27:0] a;
    logic [7:0]  d;
    logic        ref_valid;
    int          ref_line;
    logic        hit_exp;

    reset = 1'b1; rd = 1'b0; we = 1'b0; addr = 28'd0; din = 8'd0;
    for (int i = 0; i < 8; i++) begin
      ddr_mem[16 + i] = 8'(i + 1);
      ref_mem[16 + i] = 8'(i + 1);
    end
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;

    // reset state
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_rd", 64'(DDRAM_RD), 64'd0);
    chk("rst_we", 64'(DDRAM_WE), 64'd0);
    chk("rst_burst", 64'(DDRAM_BURSTCNT), 64'd1);
    chk("rst_be", 64'(DDRAM_BE), 64'd0);

    // 1: single byte write, no stall
    wc0 = wr_cmds;
    issue(1'b0, 1'b1, 28'h0000005, 8'hA5);
    ref_mem[5] = 8'hA5;
    chk("t1_we", 64'(DDRAM_WE), 64'd1);
    chk("t1_be", 64'(DDRAM_BE), 64'h20);
    chk("t1_din", DDRAM_DIN, 64'hA5A5A5A5A5A5A5A5);
    chk("t1_addr", 64'(DDRAM_ADDR), 64'(exp_word(28'h5)));
    wait_ready(lat);
    chk("t1_lat", 64'(lat), 64'd2);
    chk("t1_we_drop", 64'(DDRAM_WE), 64'd0);
    chk("t1_wr_cmds", 64'(wr_cmds - wc0), 64'd1);

    // 2: read miss then sequential hit
    rd_lat = 5;
    rc0 = rd_cmds;
    issue(1'b1, 1'b0, 28'h0000010, 8'h00);
    wait_ready(lat);
    chk("t2_miss_dout", 64'(dout), 64'h01);
    chk("t2_miss_slow", 64'(lat > 2), 64'd1);
    chk("t2_miss_cmds", 64'(rd_cmds - rc0), 64'd1);
    issue(1'b1, 1'b0, 28'h0000013, 8'h00);
    wait_ready(lat);
    chk("t2_hit_lat", 64'(lat), 64'd2);
    chk("t2_hit_dout", 64'(dout), 64'h04);
    chk("t2_hit_cmds", 64'(rd_cmds - rc0), 64'd1);

    // 3: read command held through four busy cycles
    rd_lat = 2;
    busy_force = 1'b1;
    rc0 = rd_cmds;
    issue(1'b1, 1'b0, 28'h0000040, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_sys);
      chk("t3_rd_held", 64'(DDRAM_RD), 64'd1);
      chk("t3_addr_held", 64'(DDRAM_ADDR), 64'(exp_word(28'h40)));
      if (i == 4) busy_force = 1'b0;
    end
    wait_ready(lat);
    chk("t3_one_cmd", 64'(rd_cmds - rc0), 64'd1);
    chk("t3_dout", 64'(dout), 64'(ref_rd(28'h40)));
    chk("t3_rd_low", 64'(DDRAM_RD), 64'd0);

    // 4: reset while a read is in flight; stale beats must drain first
    rd_lat = 8;
    rc0 = rd_cmds;
    b0 = beats_served;
    issue(1'b1, 1'b0, 28'h0000030, 8'h00);
    n = 0;
    while (rd_cmds == rc0 && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    chk("t4_cmd_seen", 64'(rd_cmds - rc0), 64'd1);
    do_reset();
    issue(1'b1, 1'b0, 28'h0000020, 8'h00);
    wait_ready(lat);
    chk("t4_dout", 64'(dout), 64'(ref_rd(28'h20)));
    chk("t4_cmds", 64'(rd_cmds - rc0), 64'd2);
    stale_cyc = (beat_cyc_q.size() >= b0 + BEATS) ? beat_cyc_q[b0 + BEATS - 1] : 32'h7FFFFFFF;
    chk("t4_order", 64'(last_cmd_cyc > stale_cyc), 64'd1);

    // 5: rd+we together (write wins), then rd while busy is ignored
    rd_lat = 3;
    busy_force = 1'b1;
    rc0 = rd_cmds;
    wc0 = wr_cmds;
    @(negedge clk_sys);
    addr = 28'h0000050; din = 8'h3C; rd = 1'b1; we = 1'b1;
    @(negedge clk_sys);
    addr = 28'h0000060; rd = 1'b1; we = 1'b0;
    @(negedge clk_sys);
    rd = 1'b0;
    busy_force = 1'b0;
    ref_mem[32'h50] = 8'h3C;
    wait_ready(lat);
    repeat (4) @(negedge clk_sys);
    chk("t5_no_rd", 64'(rd_cmds - rc0), 64'd0);
    chk("t5_one_wr", 64'(wr_cmds - wc0), 64'd1);
    chk("t5_ready", 64'(ready), 64'd1);
    issue(1'b1, 1'b0, 28'h0000050, 8'h00);
    wait_ready(lat);
    chk("t5_readback", 64'(dout), 64'h3C);

    // 6: line geometry (burst size, aligned address, second byte from cache)
    rc0 = rd_cmds;
    issue(1'b1, 1'b0, 28'h0000008, 8'h00);
    chk("t6_burst", 64'(DDRAM_BURSTCNT), 64'(BEATS));
    chk("t6_addr", 64'(DDRAM_ADDR), 64'(exp_word(28'h8)));
    wait_ready(lat);
    chk("t6_dout0", 64'(dout), 64'(ref_rd(28'h8)));
    issue(1'b1, 1'b0, 28'h000000F, 8'h00);
    wait_ready(lat);
    chk("t6_hit_lat", 64'(lat), 64'd2);
    chk("t6_hit_cmds", 64'(rd_cmds - rc0), 64'd1);
    chk("t6_dout1", 64'(dout), 64'(ref_rd(28'hF)));

    // randomized traffic against the reference model
    do_reset();
    ref_valid = 1'b0;
    ref_line = 0;
    rand_busy_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      n = $urandom_range(0, 9);
      if (k % 40 == 39) a = 28'hFFFFFF8 + 28'($urandom_range(0, 7));
      else a = 28'($urandom_range(0, 127));
      rd_lat = $urandom_range(1, 6);
      if (n == 0) begin
        do_reset();
        ref_valid = 1'b0;
      end else if (n < 4) begin
        d = 8'($urandom);
        wc0 = wr_cmds;
        issue(1'b0, 1'b1, a, d);
        ref_mem[int'(a)] = d;
        wait_ready(lat);
        chk("rnd_wr_cmds", 64'(wr_cmds - wc0), 64'd1);
      end else begin
        hit_exp = ref_valid && (int'(a >> OFS) == ref_line);
        rc0 = rd_cmds;
        issue(1'b1, 1'b0, a, 8'h00);
        wait_ready(lat);
        chk("rnd_rd_dout", 64'(dout), 64'(ref_rd(a)));
        if (hit_exp) begin
          chk("rnd_hit_lat", 64'(lat), 64'd2);
          chk("rnd_hit_cmds", 64'(rd_cmds - rc0), 64'd0);
        end else begin
          chk("rnd_miss_cmds", 64'(rd_cmds - rc0), 64'd1);
        end
        ref_valid = 1'b1;
        ref_line = int'(a >> OFS);
      end
    end
    rand_busy_en = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("base_hi", 64'(bad_base), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
